// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard signal bundle.
// The master drives the decoded instruction and the core controls; the slave returns the stall and clear controls.
interface hazard_scoreboard_if #(
  parameter int unsigned NREG   = 16,
  parameter int unsigned RW     = 4,
  parameter int unsigned LAT_W  = 3,
  parameter int unsigned PERF_W = 16
);
  logic              id_valid;
  logic [RW-1:0]     id_rs;
  logic [RW-1:0]     id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [RW-1:0]     id_rd;
  logic              id_wr_en;
  logic [LAT_W-1:0]  id_lat;
  logic              do_jump;
  logic              run;
  logic              stall;
  logic              pc_write_en;
  logic              if_id_write_en;
  logic              if_id_clean;
  logic              id_ex_clean;
  logic              ex_mem_clean;
  logic [NREG-1:0]   busy_vec;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr_en, id_lat, do_jump, run,
    input  stall, pc_write_en, if_id_write_en, if_id_clean, id_ex_clean, ex_mem_clean,
           busy_vec, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr_en, id_lat, do_jump, run,
    output stall, pc_write_en, if_id_write_en, if_id_clean, id_ex_clean, ex_mem_clean,
           busy_vec, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: stalls RAW/WAW hazards until the producer is forwardable,
// and kills young in-flight writers on a taken jump.
module hazard_scoreboard #(
  parameter int unsigned NREG    = 16,
  parameter int unsigned RW      = 4,
  parameter int unsigned LAT_W   = 3,
  parameter int unsigned FLUSH_D = 3,
  parameter int unsigned PERF_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave hz
);
  localparam int unsigned AGE_W = $clog2(FLUSH_D + 1) + 2;

  logic [LAT_W-1:0]  cnt_q [NREG];
  logic [LAT_W-1:0]  cnt_d [NREG];
  logic [AGE_W-1:0]  age_q [NREG];
  logic [AGE_W-1:0]  age_d [NREG];
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] stall_cycles_d;
  logic              raw;
  logic              waw;
  logic              stall;
  logic              issue;
  logic [NREG-1:0]   busy;

  // Hazard detection against the current scoreboard; r0 is never a hazard.
  always_comb begin
    raw   = (hz.id_use_rs && (hz.id_rs != '0) && (cnt_q[hz.id_rs] != '0)) ||
            (hz.id_use_rt && (hz.id_rt != '0) && (cnt_q[hz.id_rt] != '0));
    waw   = hz.id_wr_en && (hz.id_rd != '0) && (cnt_q[hz.id_rd] > hz.id_lat);
    stall = hz.id_valid && hz.run && !hz.do_jump && (raw || waw);
    issue = hz.id_valid && hz.run && !stall && !hz.do_jump;
  end

  // Scoreboard next state: flush kill, then issue, else countdown.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      age_d[r] = age_q[r];
      busy[r]  = (cnt_q[r] != '0);
      if (r != 0) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end
        if (age_q[r] != '1) begin
          age_d[r] = age_q[r] + AGE_W'(1);
        end
        if (hz.do_jump) begin
          if (age_q[r] < AGE_W'(FLUSH_D)) begin
            cnt_d[r] = '0;
          end
        end else if (issue && hz.id_wr_en && (hz.id_rd == RW'(r))) begin
          cnt_d[r] = hz.id_lat;
          age_d[r] = '0;
        end
      end else begin
        cnt_d[r] = '0;
        age_d[r] = '1;
      end
    end
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
        age_q[r] <= '1;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
        age_q[r] <= age_d[r];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.stall          = stall;
  assign hz.pc_write_en    = !stall;
  assign hz.if_id_write_en = !stall;
  assign hz.if_id_clean    = hz.do_jump;
  assign hz.id_ex_clean    = hz.do_jump || stall;
  assign hz.ex_mem_clean   = hz.do_jump;
  assign hz.busy_vec       = busy;
  assign hz.stall_cycles   = stall_cycles_q;
endmodule
